div_unit_pipelined: RTL and testbench
=====================================

# div_unit_pipelined

Parametrised successor of the integer divide execution unit. Accepts RISC-V DIV/DIVU/REM/REMU operations into an in-order input queue of configurable depth. Executes them on an internal radix-2 early-terminating divider, reuses the prior result for div/rem pairs, and returns results through a done/ack writeback handshake. Sits between the issue stage and the writeback arbiter.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, 8..64
- QUEUE_DEPTH, 2, input queue entries; ≥1
- ID_WIDTH, 3, instruction id width
- ADDR_WIDTH, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous and active-high
- issue_valid  in  1  operation presented
- issue_ready  out  1  queue can accept (not full)
- issue_fn  in  2  fn3[1:0]: bit0=1 unsigned, bit1=1 remainder
- issue_rs1, issue_rs2  in  DATA_WIDTH each  operand values
- issue_rs1_addr, issue_rs2_addr, issue_rd_addr  in  ADDR_WIDTH each  register addresses
- issue_id  in  ID_WIDTH  instruction id
- rd_write_valid  in  1  any unit issued an instruction writing rd_write_addr
- rd_write_addr  in  ADDR_WIDTH  destination of that instruction
- flush  in  1  global clear
- wb_done  out  1  result valid
- wb_id  out  ID_WIDTH  id of result
- wb_rd  out  DATA_WIDTH  result value
- wb_ack  in  1  writeback accepted

## Operation
- Push = issue_valid & issue_ready. Entry stores: unsigned dividend/divisor (two's-complement magnitude when signed and negative), both CLZ values, divisor_is_zero, remainder_op, negate_result, reuse flag, id.
- negate_result: rem → signed & rs1[MSB]; div → signed & (rs1[MSB]^rs2[MSB]) & ~divisor_is_zero.
- Reuse tag {valid, rs1_addr, rs2_addr, unsigned} of the last pushed op. A new op is flagged reuse when the tag is valid and matches on all three fields. Signedness is part of the match.
- Tag set on push unless issue_rd_addr equals issue_rs1_addr or issue_rs2_addr (tag then cleared). Tag cleared when rd_write_valid and rd_write_addr matches either stored rs address. On a simultaneous push and clear, the push outcome wins.
- FSM: IDLE → DIVIDE on pop of a non-reuse entry; IDLE → DONE on pop of a reuse entry. DIVIDE → DONE after K iterations. DONE → IDLE on wb_ack, or directly DIVIDE/DONE if the queue head pops in the same cycle.
- Pop when the queue is non-empty and (state==IDLE or (state==DONE & wb_ack)).
- K = 1 if divisor_is_zero or dividend_CLZ > divisor_CLZ; otherwise divisor_CLZ − dividend_CLZ + 1. A restoring shift-subtract step runs each DIVIDE cycle, starting from the divisor aligned to the dividend's MSB.
- Divisor zero: quotient = all ones, remainder = dividend (magnitude); sign fixup restores the original rs1.
- Overflow (signed MIN / −1): yields quotient MIN, remainder 0, with no special case.
- Result registers (unsigned quotient, remainder) persist after DONE for reuse. A reuse op leaves them untouched.
- wb_rd = negate_if(remainder_op ? rem : quot, negate_result); wb_id from the popped entry.
- flush: empties the queue, clears the reuse tag, and forces the FSM to IDLE. It also deasserts wb_done next cycle. Flush has priority over push, pop, and ack.

## Timing
- Reset values: wb_done=0, wb_id=0, wb_rd=0 (result regs 0), issue_ready=1, queue empty, tag invalid, FSM IDLE.
- issue_ready is combinational from queue occupancy only. There is no push-while-full even if a pop occurs that cycle.
- No bypass: an op pushed in cycle 0 pops at the earliest in cycle 1.
- Non-reuse: wb_done asserts in cycle pop+K+1. Reuse: wb_done asserts in cycle pop+1.
- wb_done, wb_id, wb_rd hold stable until the cycle wb_ack is sampled high. wb_ack while wb_done=0 is ignored.
- Back-to-back: ack in cycle N with a non-empty queue → next wb_done at N+K+1 (reuse: N+1). Throughput for reuse pairs is one result every cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Test plan
- DIV 20/−3 (rs1=1, rs2=2), then REM with the same regs: first wb_rd=0xFFFFFFFA after K+1; second wb_rd=2, flagged reuse, done 1 cycle after pop.
- DIVU 7/0 → wb_rd=0xFFFFFFFF. REM −7/0 → wb_rd=0xFFFFFFF9. Both K=1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of same → 0.
- Reuse blocked: DIV x1/x2, then rd_write_valid addr=2, then REM x1/x2 → REM is not reused (K cycles). Also DIV then REMU with the same regs → not reused.
- Queue full (DEPTH=2): push 3 ops with wb_ack held 0 → issue_ready=0 after the third push. Results emerge in issue order after ack; each ack is followed by the next result at the cycle given above.
- flush during DIVIDE with 2 queued ops → next cycle wb_done=0, queue empty, issue_ready=1; a following REM of the same regs is not reused. Async rst pulse mid-DIVIDE → outputs at reset values immediately.

Source files
------------

// File: rtl/div_unit_pipelined.sv
// Queued RISC-V integer divide unit: in-order input queue, radix-2 early-terminating
// restoring divider, div/rem result reuse, and a done/ack writeback handshake.
module div_unit_pipelined #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 2,
    parameter int ID_WIDTH    = 3,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [1:0]            issue_fn,
    input  logic [DATA_WIDTH-1:0] issue_rs1,
    input  logic [DATA_WIDTH-1:0] issue_rs2,
    input  logic [ADDR_WIDTH-1:0] issue_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] issue_rs2_addr,
    input  logic [ADDR_WIDTH-1:0] issue_rd_addr,
    input  logic [ID_WIDTH-1:0]   issue_id,
    input  logic                  rd_write_valid,
    input  logic [ADDR_WIDTH-1:0] rd_write_addr,
    input  logic                  flush,
    output logic                  wb_done,
    output logic [ID_WIDTH-1:0]   wb_id,
    output logic [DATA_WIDTH-1:0] wb_rd,
    input  logic                  wb_ack
);

    localparam int CLZ_W = $clog2(DATA_WIDTH) + 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dividend;
        logic [DATA_WIDTH-1:0] divisor;
        logic [CLZ_W-1:0]      dividend_clz;
        logic [CLZ_W-1:0]      divisor_clz;
        logic                  divisor_is_zero;
        logic                  remainder_op;
        logic                  negate_result;
        logic                  reuse;
        logic [ID_WIDTH-1:0]   id;
    } entry_t;

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    function automatic logic [CLZ_W-1:0] clz(input logic [DATA_WIDTH-1:0] v);
        clz = CLZ_W'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (v[i]) clz = CLZ_W'(DATA_WIDTH - 1 - i);
        end
    endfunction

    state_t                state, next_state;
    entry_t                queue_mem [QUEUE_DEPTH];
    entry_t                new_entry, head;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push, pop;
    logic                  tag_valid, tag_unsigned, tag_hit;
    logic [ADDR_WIDTH-1:0] tag_rs1, tag_rs2;
    logic                  rs1_neg, rs2_neg;
    logic [DATA_WIDTH-1:0] quot, rem, div_shift, selected;
    logic [CLZ_W-1:0]      iter_count, head_k, head_shift;
    logic                  out_rem_op, out_negate;
    logic [ID_WIDTH-1:0]   out_id;

    assign issue_ready = (count != CNT_W'(QUEUE_DEPTH));
    assign push        = issue_valid & issue_ready & ~flush;
    assign pop         = ~flush & (count != '0) &
                         ((state == IDLE) | ((state == DONE) & wb_ack));
    assign head        = queue_mem[rd_ptr];

    assign tag_hit = tag_valid & (tag_rs1 == issue_rs1_addr) &
                     (tag_rs2 == issue_rs2_addr) & (tag_unsigned == issue_fn[0]);

    // Operands are stored as unsigned magnitudes; the sign is folded into negate_result.
    always_comb begin
        rs1_neg                   = ~issue_fn[0] & issue_rs1[DATA_WIDTH-1];
        rs2_neg                   = ~issue_fn[0] & issue_rs2[DATA_WIDTH-1];
        new_entry                 = '0;
        new_entry.dividend        = rs1_neg ? ('0 - issue_rs1) : issue_rs1;
        new_entry.divisor         = rs2_neg ? ('0 - issue_rs2) : issue_rs2;
        new_entry.dividend_clz    = clz(new_entry.dividend);
        new_entry.divisor_clz     = clz(new_entry.divisor);
        new_entry.divisor_is_zero = (issue_rs2 == '0);
        new_entry.remainder_op    = issue_fn[1];
        new_entry.negate_result   = issue_fn[1] ? rs1_neg
                                    : ((rs1_neg ^ rs2_neg) & ~new_entry.divisor_is_zero);
        new_entry.reuse           = tag_hit;
        new_entry.id              = issue_id;
    end

    always_ff @(posedge clk) begin
        if (push) queue_mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A push that writes one of its own sources cannot be reused by its pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid    <= 1'b0;
            tag_unsigned <= 1'b0;
            tag_rs1      <= '0;
            tag_rs2      <= '0;
        end else if (flush) begin
            tag_valid <= 1'b0;
        end else if (push) begin
            tag_valid    <= (issue_rd_addr != issue_rs1_addr) && (issue_rd_addr != issue_rs2_addr);
            tag_unsigned <= issue_fn[0];
            tag_rs1      <= issue_rs1_addr;
            tag_rs2      <= issue_rs2_addr;
        end else if (rd_write_valid && (rd_write_addr == tag_rs1 || rd_write_addr == tag_rs2)) begin
            tag_valid <= 1'b0;
        end
    end

    // Short cases (zero divisor, dividend < divisor) still take one step so timing is uniform.
    always_comb begin
        head_k = '0;
        if (head.divisor_is_zero || (head.dividend_clz > head.divisor_clz))
            head_k = CLZ_W'(1);
        else
            head_k = head.divisor_clz - head.dividend_clz + CLZ_W'(1);
        head_shift = head_k - CLZ_W'(1);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop) next_state = head.reuse ? DONE : DIVIDE;
            DIVIDE:  if (iter_count == CLZ_W'(1)) next_state = DONE;
            DONE:    if (wb_ack) next_state = pop ? (head.reuse ? DONE : DIVIDE) : IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot       <= '0;
            rem        <= '0;
            div_shift  <= '0;
            iter_count <= '0;
            out_id     <= '0;
            out_rem_op <= 1'b0;
            out_negate <= 1'b0;
        end else if (pop) begin
            out_id     <= head.id;
            out_rem_op <= head.remainder_op;
            out_negate <= head.negate_result;
            if (!head.reuse) begin
                rem        <= head.dividend;
                quot       <= head.divisor_is_zero ? '1 : '0;
                div_shift  <= head.divisor << head_shift;
                iter_count <= head_k;
            end
        end else if (state == DIVIDE && !flush) begin
            if (rem >= div_shift) begin
                rem  <= rem - div_shift;
                quot <= {quot[DATA_WIDTH-2:0], 1'b1};
            end else begin
                quot <= {quot[DATA_WIDTH-2:0], 1'b0};
            end
            div_shift  <= div_shift >> 1;
            iter_count <= iter_count - CLZ_W'(1);
        end
    end

    assign selected = out_rem_op ? rem : quot;
    assign wb_rd    = out_negate ? ('0 - selected) : selected;
    assign wb_id    = out_id;
    assign wb_done  = (state == DONE);

endmodule

// File: tb/tb_div_unit_pipelined.sv
// Directed bench for div_unit_pipelined: latency, reuse, queue, flush and reset behaviour
// against hand-computed results (DATA_WIDTH=32, QUEUE_DEPTH=2).
module tb_div_unit_pipelined;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_fn;
    logic [31:0] issue_rs1, issue_rs2;
    logic [4:0]  issue_rs1_addr, issue_rs2_addr, issue_rd_addr;
    logic [2:0]  issue_id;
    logic        rd_write_valid;
    logic [4:0]  rd_write_addr;
    logic        flush;
    logic        wb_done;
    logic [2:0]  wb_id;
    logic [31:0] wb_rd;
    logic        wb_ack;

    int errors = 0;
    int checks = 0;

    div_unit_pipelined #(
        .DATA_WIDTH(32), .QUEUE_DEPTH(2), .ID_WIDTH(3), .ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fn(issue_fn),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_addr(issue_rs1_addr), .issue_rs2_addr(issue_rs2_addr),
        .issue_rd_addr(issue_rd_addr), .issue_id(issue_id),
        .rd_write_valid(rd_write_valid), .rd_write_addr(rd_write_addr),
        .flush(flush), .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one issue beat starting at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                                 input logic [2:0] id);
        issue_valid    = 1'b1;
        issue_fn       = fn;
        issue_rs1      = a;
        issue_rs2      = b;
        issue_rs1_addr = ra;
        issue_rs2_addr = rb;
        issue_rd_addr  = rd;
        issue_id       = id;
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic ackResult();
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
    endtask

    // Counts falling edges until wb_done, checks the result, then acknowledges it.
    task automatic expectResult(input string tag, input int lat, input logic [2:0] id, input logic [31:0] val);
        int n = 0;
        while (!wb_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'(lat));
        checkOutput({tag, "_id"}, 64'(wb_id), 64'(id));
        checkOutput({tag, "_rd"}, 64'(wb_rd), 64'(val));
        ackResult();
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_fn = '0; issue_rs1 = '0; issue_rs2 = '0;
        issue_rs1_addr = '0; issue_rs2_addr = '0; issue_rd_addr = '0; issue_id = '0;
        rd_write_valid = 1'b0; rd_write_addr = '0; flush = 1'b0; wb_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_done", 64'(wb_done), 64'd0);
        checkOutput("reset_id", 64'(wb_id), 64'd0);
        checkOutput("reset_rd", 64'(wb_rd), 64'd0);
        checkOutput("reset_ready", 64'(issue_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // 20 / -3: K=4; paired REM reuses the quotient/remainder registers
        applyStimulus(2'b00, 32'd20, 32'hFFFF_FFFD, 5'd1, 5'd2, 5'd3, 3'd1);
        applyStimulus(2'b10, 32'd20, 32'hFFFF_FFFD, 5'd1, 5'd2, 5'd4, 3'd2);
        expectResult("div_20_m3", 4, 3'd1, 32'hFFFF_FFFA);
        expectResult("rem_reuse", 0, 3'd2, 32'd2);
        checkOutput("idle_after_ack", 64'(wb_done), 64'd0);

        // Divide by zero, K=1
        applyStimulus(2'b01, 32'd7, 32'd0, 5'd5, 5'd6, 5'd7, 3'd3);
        expectResult("divu_by0", 2, 3'd3, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd8, 5'd9, 5'd10, 3'd4);
        expectResult("rem_by0", 2, 3'd4, 32'hFFFF_FFF9);

        // Signed overflow, K=32; REM of the same regs reused one cycle after pop
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 5'd12, 5'd13, 3'd5);
        expectResult("div_ovf", 33, 3'd5, 32'h8000_0000);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 5'd12, 5'd14, 3'd6);
        expectResult("rem_ovf_reuse", 1, 3'd6, 32'd0);

        // Reuse blocking: rd write to a source, signedness change, rd equal to a source
        applyStimulus(2'b00, 32'd100, 32'd7, 5'd1, 5'd2, 5'd3, 3'd7);
        expectResult("div_100_7", 6, 3'd7, 32'd14);
        rd_write_valid = 1'b1;
        rd_write_addr  = 5'd2;
        @(negedge clk);
        rd_write_valid = 1'b0;
        applyStimulus(2'b10, 32'd100, 32'd7, 5'd1, 5'd2, 5'd3, 3'd0);
        expectResult("rem_after_wr", 6, 3'd0, 32'd2);
        applyStimulus(2'b00, 32'd100, 32'd7, 5'd1, 5'd2, 5'd3, 3'd1);
        expectResult("div_reuse", 1, 3'd1, 32'd14);
        applyStimulus(2'b11, 32'd100, 32'd7, 5'd1, 5'd2, 5'd3, 3'd2);
        expectResult("remu_no_reuse", 6, 3'd2, 32'd2);
        applyStimulus(2'b00, 32'd100, 32'd7, 5'd1, 5'd2, 5'd1, 3'd3);
        expectResult("div_rd_eq_rs", 6, 3'd3, 32'd14);
        applyStimulus(2'b10, 32'd100, 32'd7, 5'd1, 5'd2, 5'd4, 3'd4);
        expectResult("rem_tag_cleared", 6, 3'd4, 32'd2);

        // Queue full with ack held low, then in-order drain
        applyStimulus(2'b01, 32'd100, 32'd7, 5'd15, 5'd16, 5'd17, 3'd5);
        applyStimulus(2'b11, 32'd100, 32'd7, 5'd15, 5'd16, 5'd18, 3'd6);
        checkOutput("ready_before_full", 64'(issue_ready), 64'd1);
        applyStimulus(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd18, 5'd19, 5'd20, 3'd7);
        checkOutput("ready_full", 64'(issue_ready), 64'd0);
        repeat (7) @(negedge clk);
        checkOutput("hold_done", 64'(wb_done), 64'd1);
        checkOutput("hold_id", 64'(wb_id), 64'd5);
        checkOutput("hold_rd", 64'(wb_rd), 64'd14);
        ackResult();
        checkOutput("ready_after_pop", 64'(issue_ready), 64'd1);
        expectResult("queue_b", 0, 3'd6, 32'd2);
        expectResult("queue_c", 5, 3'd7, 32'hFFFF_FFF2);
        checkOutput("drained_done", 64'(wb_done), 64'd0);

        // Flush mid-divide with two queued ops; the last one set the tag for x21/x22
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 5'd22, 5'd23, 3'd1);
        applyStimulus(2'b01, 32'd100, 32'd7, 5'd25, 5'd26, 5'd27, 3'd2);
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 5'd22, 5'd27, 3'd3);
        checkOutput("ready_pre_flush", 64'(issue_ready), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_done", 64'(wb_done), 64'd0);
        checkOutput("flush_ready", 64'(issue_ready), 64'd1);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 5'd22, 5'd28, 3'd4);
        expectResult("rem_after_flush", 33, 3'd4, 32'd0);

        // Asynchronous reset in the middle of a long divide with a full queue
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd3, 3'd5);
        applyStimulus(2'b01, 32'd9, 32'd3, 5'd4, 5'd5, 5'd6, 3'd6);
        applyStimulus(2'b01, 32'd9, 32'd3, 5'd7, 5'd8, 5'd9, 3'd2);
        repeat (3) @(negedge clk);
        checkOutput("id_before_rst", 64'(wb_id), 64'd5);
        checkOutput("ready_before_rst", 64'(issue_ready), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_done", 64'(wb_done), 64'd0);
        checkOutput("async_rst_id", 64'(wb_id), 64'd0);
        checkOutput("async_rst_rd", 64'(wb_rd), 64'd0);
        checkOutput("async_rst_ready", 64'(issue_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(2'b01, 32'd9, 32'd3, 5'd4, 5'd5, 5'd6, 3'd6);
        expectResult("divu_after_rst", 4, 3'd6, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
